bb_uart_frame_rx: RTL and testbench



---
 rtl/bb_uart_frame_rx.sv | 213 +++++++++++++++++++++
 tb/tb_bb_uart_frame_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_uart_frame_rx.sv
// UART receive front end: deserialises 8N1 bytes (8E1 when FRAME_PARITY_EN is defined)
// and assembles DATA_WIDTH/8 of them, LSB lane first, into one frame word with a ready level.
module bb_uart_frame_rx #(
    parameter int unsigned CLOCKS_PER_PULSE = 5208,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned TIMEOUT_BITS     = 20
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic                  ready,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned NBYTES    = DATA_WIDTH / 8;
    localparam int unsigned HALF      = CLOCKS_PER_PULSE / 2;
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLOCKS_PER_PULSE;
    localparam int unsigned BAUD_W    = $clog2(CLOCKS_PER_PULSE);
    localparam int unsigned IDLE_W    = $clog2(TO_CYCLES + 1);
    localparam int unsigned BCNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef FRAME_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e                  state_q, state_d;
    logic                    rx_meta_q, rx_s_q;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic [2:0]              bit_q, bit_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [7:0]              shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   word_c;
    logic                    bit_sample_c;
    logic                    drop_c;

    assign data_output = data_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign frame_err   = err_q;

    // State and datapath registers, rx resynchronised through two flops
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            baud_q    <= '0;
            idle_q    <= '0;
            bit_q     <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            asm_q     <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            baud_q    <= baud_d;
            idle_q    <= idle_d;
            bit_q     <= bit_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            asm_q     <= asm_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bit_sample_c = (baud_q == BAUD_W'(CLOCKS_PER_PULSE - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idle_d  = '0;
        bit_d   = bit_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        asm_d   = asm_q;
        data_d  = data_q;
        ready_d = ready_q;
        err_d   = 1'b0;
        drop_c  = 1'b0;
        word_c  = asm_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                // Timeout is evaluated before start detection so it wins a same-cycle tie
                if (bcnt_q != '0) begin
                    if (idle_q == IDLE_W'(TO_CYCLES - 1)) begin
                        err_d  = 1'b1;
                        bcnt_d = '0;
                        asm_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                if (!rx_s_q) begin
                    state_d = S_START;
                    idle_d  = '0;
                end
            end
            S_START: begin
                baud_d = baud_q + 1'b1;
                if (baud_q == BAUD_W'(HALF - 1)) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        if (bcnt_q == '0 && ready_q) begin
                            ready_d = 1'b0;
                        end
                    end
                end
            end
            S_DATA: begin
                baud_d = baud_q + 1'b1;
                if (bit_sample_c) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef FRAME_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef FRAME_PARITY_EN
            S_PARITY: begin
                baud_d = baud_q + 1'b1;
                if (bit_sample_c) begin
                    baud_d = '0;
                    if ((^shift_q) != rx_s_q) begin
                        drop_c = 1'b1;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                baud_d = baud_q + 1'b1;
                if (bit_sample_c) begin
                    baud_d = '0;
                    if (!rx_s_q) begin
                        drop_c = 1'b1;
                    end else begin
                        word_c[8*bcnt_q +: 8] = shift_q;
                        asm_d   = word_c;
                        state_d = S_IDLE;
                        if (bcnt_q == BCNT_W'(NBYTES - 1)) begin
                            data_d  = word_c;
                            ready_d = 1'b1;
                            bcnt_d  = '0;
                            asm_d   = '0;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Require a full bit period of idle line so a held break cannot resync
                if (!rx_s_q) begin
                    baud_d = '0;
                end else if (bit_sample_c) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drop_c) begin
            err_d   = 1'b1;
            bcnt_d  = '0;
            asm_d   = '0;
            state_d = S_WAIT_IDLE;
        end

        busy_d = !(state_d == S_IDLE || state_d == S_WAIT_IDLE);
    end

endmodule

// File: tb/tb_bb_uart_frame_rx.sv
// Randomised bench for bb_uart_frame_rx: a byte-queue model predicts frame words,
// ready level and frame_err pulse count; FRAME_PARITY_EN adds the even-parity cases.
module tb_bb_uart_frame_rx;

    localparam int unsigned CPP   = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned TOB   = 20;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned LIMIT = TOB * CPP;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rx;
    logic [DW-1:0] data_output;
    logic          ready;
    logic          busy;
    logic          frame_err;

    bb_uart_frame_rx #(
        .CLOCKS_PER_PULSE(CPP),
        .DATA_WIDTH      (DW),
        .TIMEOUT_BITS    (TOB)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .data_output(data_output),
        .ready      (ready),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and output monitor, sampled on the falling edge
    int   cyc = 0;
    int   err_cnt = 0;
    int   err_runs = 0;
    int   busy_cyc = 0;
    int   ready_rise_cyc = -1;
    logic err_prev = 1'b0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) begin
            err_cnt++;
            if (err_prev) err_runs++;
        end
        if (ready && !ready_prev) ready_rise_cyc = cyc;
        if (busy) busy_cyc++;
        err_prev   = frame_err;
        ready_prev = ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: bytes of the frame in progress, last word, ready level, error count
    logic [7:0]    pend[$];
    logic [DW-1:0] m_word = '0;
    logic          m_ready = 1'b0;
    int            m_err = 0;

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (pend.size() == 0) m_ready = 1'b0;
        if (good) begin
            pend.push_back(b);
            if (pend.size() == NB) begin
                for (int k = 0; k < NB; k++) m_word[8*k +: 8] = pend[k];
                m_ready = 1'b1;
                pend.delete();
            end
        end else begin
            pend.delete();
            m_err++;
        end
    endfunction

    function automatic void model_idle(input int n);
        if (pend.size() != 0 && n > LIMIT) begin
            pend.delete();
            m_err++;
        end
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_word  = '0;
        m_ready = 1'b0;
    endfunction

`ifdef FRAME_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int stop_c);
        rx = 1'b0;
        tick(CPP);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPP);
        end
`ifdef FRAME_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPP);
`endif
        stop_c = cyc;
        rx = stop_bit;
        tick(CPP);
    endtask

    task automatic send_good(input logic [7:0] b);
        int stop_c;
        bit completes;
        completes = (pend.size() == NB - 1);
        send_byte(b, 1'b1, stop_c);
        model_byte(b, 1'b1);
        if (completes)
            check_eq("ready_rise_window",
                     64'((ready_rise_cyc >= stop_c + 2) && (ready_rise_cyc <= stop_c + int'(CPP) + 2)),
                     64'd1);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int k = 0; k < NB; k++) send_good(w[8*k +: 8]);
    endtask

    task automatic checkpoint(input string tag);
        check_eq({tag, "_data"},  64'(data_output), 64'(m_word));
        check_eq({tag, "_ready"}, 64'(ready),       64'(m_ready));
        check_eq({tag, "_errs"},  64'(err_cnt),     64'(m_err));
    endtask

    initial begin
        int b0;
        int stop_c;
        int g;
        logic [7:0] rb;
        logic [7:0] b2;

        rstn = 1'b0;
        rx   = 1'b1;
        tick(4);
        check_eq("rst_data",  64'(data_output), 64'd0);
        check_eq("rst_ready", 64'(ready),       64'd0);
        check_eq("rst_busy",  64'(busy),        64'd0);
        check_eq("rst_err",   64'(frame_err),   64'd0);
        rstn = 1'b1;
        tick(2 * CPP);

        // Back-to-back frame
        send_word(32'h81AB_1234);
        checkpoint("b2b");
        check_eq("b2b_word", 64'(data_output), 64'h81AB_1234);

        // False start: short low glitch
        b0 = busy_cyc;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(CPP);
        check_eq("fs_busy_seen", 64'(busy_cyc > b0), 64'd1);
        check_eq("fs_busy_low",  64'(busy),          64'd0);
        checkpoint("fs");
        send_word(32'hDEAD_BEEF);
        checkpoint("fs_frame");
        check_eq("fs_word", 64'(data_output), 64'hDEAD_BEEF);

        // Framing error followed by a held-low line
        send_good(8'h11);
        send_byte(8'h22, 1'b0, stop_c);
        model_byte(8'h22, 1'b0);
        tick(40);
        check_eq("brk_busy", 64'(busy), 64'd0);
        checkpoint("ferr");
        rx = 1'b1;
        tick(2 * CPP);
        send_word(32'h0403_0201);
        checkpoint("ferr_frame");
        check_eq("ferr_word", 64'(data_output), 64'h0403_0201);

        // Inter-byte timeout drops the partial frame
        send_good(8'h55);
        send_good(8'h66);
        tick(LIMIT + 1);
        model_idle(LIMIT + 1);
        checkpoint("tmo");
        send_word(32'hA3A2_A1A0);
        checkpoint("tmo_frame");
        check_eq("tmo_word", 64'(data_output), 64'hA3A2_A1A0);

        // Gap just under the timeout keeps the partial frame
        send_good(8'hC1);
        send_good(8'hC2);
        tick(LIMIT - 32);
        model_idle(LIMIT - 32);
        send_good(8'hC3);
        send_good(8'hC4);
        checkpoint("near_tmo");
        check_eq("near_tmo_word", 64'(data_output), 64'hC4C3_C2C1);

        // Reset during bit 3 of byte 2
        send_good(8'h5A);
        send_good(8'hA5);
        b2 = 8'h96;
        rx = 1'b0;
        tick(CPP);
        for (int i = 0; i < 3; i++) begin
            rx = b2[i];
            tick(CPP);
        end
        rx = b2[3];
        tick(CPP / 2);
        rstn = 1'b0;
        tick(1);
        check_eq("mid_rst_data",  64'(data_output), 64'd0);
        check_eq("mid_rst_ready", 64'(ready),       64'd0);
        check_eq("mid_rst_busy",  64'(busy),        64'd0);
        check_eq("mid_rst_err",   64'(frame_err),   64'd0);
        rx = 1'b1;
        tick(2);
        rstn = 1'b1;
        model_reset();
        tick(2 * CPP);
        send_word(32'h4030_2010);
        checkpoint("post_rst");
        check_eq("post_rst_word", 64'(data_output), 64'h4030_2010);

        // Random frames with random inter-byte gaps
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < NB; k++) begin
                rb = 8'($urandom_range(0, 255));
                send_good(rb);
                g = int'($urandom_range(0, 4 * CPP));
                if (g > 0) tick(g);
                model_idle(g);
            end
            checkpoint("rand");
        end

`ifdef FRAME_PARITY_EN
        // Even parity: good byte accepted, corrupted parity drops the frame
        send_good(8'h07);
        par_flip = 1'b1;
        send_byte(8'h07, 1'b1, stop_c);
        model_byte(8'h07, 1'b0);
        par_flip = 1'b0;
        tick(2 * CPP);
        checkpoint("par_bad");
        send_word(32'h0707_0707);
        checkpoint("par_frame");
        check_eq("par_word", 64'(data_output), 64'h0707_0707);
`endif

        check_eq("err_single_cycle", 64'(err_runs), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
